// File: rtl/apb_timer_slave_if.sv
// APB bus bundle for the timer slave (no pready: the bridge never waits).
// The master modport drives the request; the slave returns read data.
interface apb_timer_slave_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  modport master (output psel, output penable, output pwrite, output paddr, output pwdata, input prdata);
  modport slave  (input psel, input penable, input pwrite, input paddr, input pwdata, output prdata);
endinterface

// File: rtl/apb_timer_slave.sv
// APB down-counting timer: prescaler, one-shot/auto-reload, W1C expiry flag.
// Define APB_TIMER_IRQ_EN to build the registered interrupt (irq = EXP & IE).
module apb_timer_slave #(
  parameter int CNT_W     = 32,
  parameter int PRESC_DIV = 1
) (
  input  logic             hclk,
  input  logic             hresetn,
  apb_timer_slave_if.slave bus,
  output logic             irq
);
  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);
`ifdef APB_TIMER_IRQ_EN
  localparam logic [2:0] CTRL_MASK = 3'b111;
`else
  localparam logic [2:0] CTRL_MASK = 3'b011;
`endif

  typedef enum logic {ST_IDLE, ST_SETUP} apb_state_t;
  apb_state_t state_reg, state_next;

  logic [2:0]       ctrl_reg, ctrl_next;
  logic [CNT_W-1:0] load_reg, load_next;
  logic [CNT_W-1:0] value_reg, value_next;
  logic             exp_reg, exp_next;
  logic [PW-1:0]    presc_reg, presc_next;
  logic [31:0]      prdata_reg, prdata_next;
  logic [31:0]      rd_mux;
  logic [2:0]       reg_idx;
  logic             wr_commit, wr_ctrl, wr_load, wr_status;
  logic             tick, exp_set;

  logic unused_bits;
  assign unused_bits = &{1'b0, bus.paddr[31:5], bus.paddr[1:0], bus.pwdata};

  assign reg_idx    = bus.paddr[4:2];
  assign bus.prdata = prdata_reg;

  always_ff @(posedge hclk or posedge hresetn) begin
    if (hresetn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = ST_IDLE;
    wr_commit   = 1'b0;
    wr_ctrl     = 1'b0;
    wr_load     = 1'b0;
    wr_status   = 1'b0;
    rd_mux      = '0;
    prdata_next = '0;
    tick        = 1'b0;
    exp_set     = 1'b0;
    presc_next  = '0;
    ctrl_next   = ctrl_reg;
    load_next   = load_reg;
    value_next  = value_reg;
    exp_next    = exp_reg;

    if (bus.psel && !bus.penable) begin
      state_next = ST_SETUP;
    end
    // An access phase only counts if the previous cycle was a genuine setup.
    wr_commit = bus.psel && bus.penable && bus.pwrite && (state_reg == ST_SETUP);
    wr_ctrl   = wr_commit && (reg_idx == 3'd0);
    wr_load   = wr_commit && (reg_idx == 3'd1);
    wr_status = wr_commit && (reg_idx == 3'd3);

    case (reg_idx)
      3'd0:    rd_mux = 32'(ctrl_reg);
      3'd1:    rd_mux = 32'(load_reg);
      3'd2:    rd_mux = 32'(value_reg);
      3'd3:    rd_mux = {31'b0, exp_reg};
      default: rd_mux = '0;
    endcase
    if (bus.psel && !bus.penable && !bus.pwrite) begin
      prdata_next = rd_mux;
    end

    tick = ctrl_reg[0] && (presc_reg == PRESC_LAST);
    if (ctrl_reg[0] && !tick) begin
      presc_next = presc_reg + 1'b1;
    end

    if (tick) begin
      if (value_reg == '0) begin
        exp_set = 1'b1;
        if (ctrl_reg[1]) begin
          value_next = load_reg;
        end else begin
          ctrl_next[0] = 1'b0;
        end
      end else begin
        value_next = value_reg - 1'b1;
      end
    end

    // Software writes land last so they override the timer's own updates.
    if (wr_ctrl) begin
      ctrl_next = bus.pwdata[2:0] & CTRL_MASK;
    end
    if (wr_load) begin
      load_next  = bus.pwdata[CNT_W-1:0];
      value_next = bus.pwdata[CNT_W-1:0];
    end
    exp_next = exp_set | (exp_reg & ~(wr_status & bus.pwdata[0]));
  end

  always_ff @(posedge hclk or posedge hresetn) begin
    if (hresetn) begin
      ctrl_reg   <= '0;
      load_reg   <= '0;
      value_reg  <= '0;
      exp_reg    <= 1'b0;
      presc_reg  <= '0;
      prdata_reg <= '0;
    end else begin
      ctrl_reg   <= ctrl_next;
      load_reg   <= load_next;
      value_reg  <= value_next;
      exp_reg    <= exp_next;
      presc_reg  <= presc_next;
      prdata_reg <= prdata_next;
    end
  end

`ifdef APB_TIMER_IRQ_EN
  logic irq_reg;

  always_ff @(posedge hclk or posedge hresetn) begin
    if (hresetn) begin
      irq_reg <= 1'b0;
    end else begin
      irq_reg <= exp_reg & ctrl_reg[2];
    end
  end

  assign irq = irq_reg;
`else
  assign irq = 1'b0;
`endif
endmodule

// File: doc/apb_timer_slave.md
APB_TIMER_SLAVE -- requirements
Module: apb_timer_slave

Interface
REQ-001 SHALL have parameter CNT_W, default 32: counter and LOAD register width (8..32); register bits above CNT_W read 0.
REQ-002 SHALL have parameter PRESC_DIV, default 1: counter decrements once every PRESC_DIV hclk cycles while enabled (1..256).
REQ-003 SHALL have port hclk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port hresetn, input, 1: reset, asynchronous and active-high despite the name.
REQ-005 SHALL have port psel, input, 1: this slave's select, one bit of the bridge's psel[2:0].
REQ-006 SHALL have port penable, input, 1: APB access phase.
REQ-007 SHALL have port pwrite, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have port paddr, input, 32: byte address; only paddr[4:2] decoded.
REQ-009 SHALL have port pwdata, input, 32: write data.
REQ-010 SHALL have port prdata, output, 32: read data returned to the bridge.
REQ-011 SHALL have port irq, output, 1: level timer interrupt.

Function
REQ-012 SHALL implement these registers: 0x00 CTRL (bit0 EN, bit1 AUTO, bit2 IE), R/W; 0x04 LOAD, R/W; 0x08 VALUE, RO; 0x0C STATUS (bit0 EXP), read, write-1-to-clear.
REQ-013 SHALL treat any other paddr[4:2] as reserved: reads return 0 and writes are ignored.
REQ-014 SHALL perform no wait states, because the bridge provides no pready; every transfer is two cycles: setup (psel & !penable), then access (psel & penable).
REQ-015 SHALL commit a write on the rising edge that ends the access phase (psel & penable & pwrite), and only on that edge.
REQ-016 SHALL capture read data into the prdata register at the end of the setup phase (psel & !penable & !pwrite), so prdata is stable for the entire access phase.
REQ-017 SHALL return prdata to 0 on the cycle after the access phase, and hold it at 0 when idle or during writes.
REQ-018 SHALL also load VALUE with the new LOAD value on a write to LOAD.
REQ-019 SHALL decrement VALUE by 1 on each prescaler tick while EN = 1; the prescaler counter SHALL clear whenever EN = 0.
REQ-020 SHALL handle a tick with VALUE = 0 as follows: set EXP; reload VALUE from LOAD if AUTO = 1; otherwise hold VALUE at 0 and clear EN.
REQ-021 SHALL let a set win over a W1C clear of EXP when expiry and the clear occur on the same edge.
REQ-022 SHALL give a LOAD write priority over a decrement or reload that falls on the same edge.
REQ-023 SHALL not start the first tick before PRESC_DIV cycles after EN rises, and then tick every PRESC_DIV cycles.
REQ-024 SHALL compute VALUE modulo 2^CNT_W and never underflow below 0.
REQ-025 SHALL ignore an access phase without a preceding setup phase for writes; reads in that case return 0.

Reset
REQ-026 SHALL, while hresetn = 1, asynchronously force CTRL = 0, LOAD = 0, VALUE = 0, EXP = 0, prescaler = 0, prdata = 0 and irq = 0.
REQ-027 SHALL abort any in-flight APB transfer on reset, without committing it.
REQ-028 SHALL resume normal operation on the first rising edge after hresetn deasserts.

Configuration
REQ-029 SHALL, with macro APB_TIMER_IRQ_EN defined, drive irq = EXP & IE from a register, asserting one cycle after EXP sets.
REQ-030 SHALL, without APB_TIMER_IRQ_EN: tie irq to 0; make CTRL bit2 read 0 and ignore writes to it; leave the EXP status behaviour unchanged.

Verification
REQ-031 SHALL cover reset mid-count: with EN = 1 and VALUE = 5, assert hresetn -> all registers read 0 and irq = 0 immediately, without waiting for a clock edge.
REQ-032 SHALL cover one-shot expiry: PRESC_DIV = 1, write LOAD = 3, write CTRL = 0x1 -> VALUE reads 3, 2, 1, 0 on consecutive cycles; EXP = 1 and EN = 0 one tick after 0.
REQ-033 SHALL cover auto-reload: LOAD = 2, CTRL = 0x7 -> VALUE sequence 2, 1, 0, 2, 1, 0; EXP set at each wrap; irq = 1 (macro defined) until STATUS is written with 0x1.
REQ-034 SHALL cover a simultaneous clear and expiry: a W1C to STATUS on the same edge as expiry -> EXP remains 1.
REQ-035 SHALL cover read timing: read 0x04 after writing 0xDEADBEEF (CNT_W = 32) -> prdata = 0xDEADBEEF throughout the access phase and 0 on the next cycle; read 0x14 -> prdata = 0.
REQ-036 SHALL cover the prescaler: PRESC_DIV = 4, LOAD = 2, EN = 1 -> VALUE changes every 4th cycle; EXP sets 12 cycles after EN is written.
